// File: rtl/dispatch_scoreboard_pkg.sv
// Shared constants and types for the dispatch/scoreboard stage: field widths,
// reservation-station encodings, FSM state and the hold-register layout.
package dispatch_scoreboard_pkg;

  localparam int unsigned RS_ENT_SEL           = 3;
  localparam int unsigned REG_SEL              = 5;
  localparam int unsigned NUM_REGS             = 1 << REG_SEL;
  localparam int unsigned DISP_CREDITS_DEFAULT = 4;

  localparam logic [RS_ENT_SEL-1:0] RS_ENT_ALU    = 3'd0;
  localparam logic [RS_ENT_SEL-1:0] RS_ENT_LDST   = 3'd1;
  localparam logic [RS_ENT_SEL-1:0] RS_ENT_BRANCH = 3'd2;
  localparam logic [RS_ENT_SEL-1:0] RS_ENT_JAL    = 3'd3;
  localparam logic [RS_ENT_SEL-1:0] RS_ENT_JALR   = 3'd4;
  localparam logic [RS_ENT_SEL-1:0] RS_ENT_MUL    = 3'd5;
  localparam logic [RS_ENT_SEL-1:0] RS_ENT_DIV    = 3'd6;

  typedef enum logic [1:0] {StEmpty, StHold, StTrap} disp_state_e;

  typedef struct packed {
    logic [RS_ENT_SEL-1:0] rs_ent;
    logic [REG_SEL-1:0]    rs1;
    logic [REG_SEL-1:0]    rs2;
    logic [REG_SEL-1:0]    rd;
    logic                  uses_rs1;
    logic                  uses_rs2;
    logic                  wr_reg;
    logic                  illegal;
  } hold_entry_t;

  // A same-cycle writeback to the register lifts the hazard.
  function automatic logic reg_hazard(input logic                used,
                                      input logic [REG_SEL-1:0]  r,
                                      input logic [NUM_REGS-1:0] busy,
                                      input logic                wb_valid,
                                      input logic [REG_SEL-1:0]  wb_rd);
    return used && (r != '0) && busy[r] && !(wb_valid && (wb_rd == r));
  endfunction

endpackage

// File: rtl/dispatch_scoreboard_if.sv
// Decoder-side, dispatch-side, writeback and control signals of the dispatch stage.
// master drives the decoder/writeback inputs, slave is the dispatch block.
interface dispatch_scoreboard_if #(
  parameter int unsigned NUM_ENT = 8,
  parameter int unsigned STALL_W = 16
);
  import dispatch_scoreboard_pkg::*;

  logic                  dec_valid;
  logic                  dec_ready;
  logic [RS_ENT_SEL-1:0] rs_ent;
  logic [REG_SEL-1:0]    rs1;
  logic [REG_SEL-1:0]    rs2;
  logic [REG_SEL-1:0]    rd;
  logic                  uses_rs1;
  logic                  uses_rs2;
  logic                  wr_reg;
  logic                  illegal_instruction;
  logic [NUM_ENT-1:0]    disp_valid;
  logic [REG_SEL-1:0]    disp_rs1;
  logic [REG_SEL-1:0]    disp_rs2;
  logic [REG_SEL-1:0]    disp_rd;
  logic                  disp_wr_reg;
  logic [NUM_ENT-1:0]    rs_free;
  logic                  wb_valid;
  logic [REG_SEL-1:0]    wb_rd;
  logic                  flush;
  logic                  illegal_trap;
  logic [STALL_W-1:0]    stall_cnt;

  modport master (
    output dec_valid, rs_ent, rs1, rs2, rd, uses_rs1, uses_rs2, wr_reg,
           illegal_instruction, rs_free, wb_valid, wb_rd, flush,
    input  dec_ready, disp_valid, disp_rs1, disp_rs2, disp_rd, disp_wr_reg,
           illegal_trap, stall_cnt
  );

  modport slave (
    input  dec_valid, rs_ent, rs1, rs2, rd, uses_rs1, uses_rs2, wr_reg,
           illegal_instruction, rs_free, wb_valid, wb_rd, flush,
    output dec_ready, disp_valid, disp_rs1, disp_rs2, disp_rd, disp_wr_reg,
           illegal_trap, stall_cnt
  );

endinterface

// File: rtl/dispatch_credit_ctr.sv
// Per-station credit counter: one credit consumed per dispatch, one returned per
// free pulse, saturating at the station depth; zero_o blocks further dispatch.
module dispatch_credit_ctr #(
  parameter int unsigned CREDITS = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic take_i,
  input  logic give_i,
  output logic zero_o
);

  localparam int unsigned       CredW   = $clog2(CREDITS + 1);
  localparam logic [CredW-1:0]  CredMax = CredW'(CREDITS);

  logic [CredW-1:0] credit_q, credit_d;

  always_comb begin
    credit_d = credit_q;
    if (flush_i) begin
      credit_d = CredMax;
    end else if (take_i && !give_i) begin
      credit_d = credit_q - CredW'(1);
    end else if (give_i && !take_i && (credit_q != CredMax)) begin
      credit_d = credit_q + CredW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credit_q <= CredMax;
    end else begin
      credit_q <= credit_d;
    end
  end

  assign zero_o = (credit_q == '0);

endmodule

// File: rtl/dispatch_scoreboard.sv
// Dispatch stage: holds one decoded instruction, checks RAW/WAW hazards against a
// busy-bit scoreboard and station credits, and issues a one-hot dispatch strobe.
module dispatch_scoreboard
  import dispatch_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_ENT = 8,
  parameter int unsigned CREDITS = DISP_CREDITS_DEFAULT,
  parameter int unsigned STALL_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  dispatch_scoreboard_if.slave  bus
);

  disp_state_e         state_q, state_d;
  hold_entry_t         hold_q, hold_d;
  hold_entry_t         dec_entry;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic [NUM_ENT-1:0]  cred_zero;
  logic [NUM_ENT-1:0]  take;

  logic in_hold, hz1, hz2, waw, credit_ok, go, dispatch, trap, stall, dec_ready, accept;

  always_comb begin
    dec_entry          = '0;
    dec_entry.rs_ent   = bus.rs_ent;
    dec_entry.rs1      = bus.rs1;
    dec_entry.rs2      = bus.rs2;
    dec_entry.rd       = bus.rd;
    dec_entry.uses_rs1 = bus.uses_rs1;
    dec_entry.uses_rs2 = bus.uses_rs2;
    dec_entry.wr_reg   = bus.wr_reg;
    // Out-of-range station selects take the same path as decoder-flagged illegals.
    dec_entry.illegal  = bus.illegal_instruction || (32'(bus.rs_ent) >= NUM_ENT);
  end

  always_comb begin
    in_hold   = (state_q == StHold);
    hz1       = reg_hazard(hold_q.uses_rs1, hold_q.rs1, busy_q, bus.wb_valid, bus.wb_rd);
    hz2       = reg_hazard(hold_q.uses_rs2, hold_q.rs2, busy_q, bus.wb_valid, bus.wb_rd);
    waw       = reg_hazard(hold_q.wr_reg, hold_q.rd, busy_q, bus.wb_valid, bus.wb_rd);
    credit_ok = !cred_zero[hold_q.rs_ent];
    go        = in_hold && !hold_q.illegal && !hz1 && !hz2 && !waw && credit_ok;
    dispatch  = go && !bus.flush;
    trap      = in_hold && hold_q.illegal && !bus.flush;
    stall     = in_hold && !hold_q.illegal && !go && !bus.flush;
    dec_ready = !bus.flush && ((state_q == StEmpty) || go);
    accept    = bus.dec_valid && dec_ready;
    take      = '0;
    for (int unsigned i = 0; i < NUM_ENT; i++) begin
      take[i] = dispatch && (32'(hold_q.rs_ent) == i);
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (accept) begin
      hold_d = dec_entry;
    end
    if (bus.flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: if (accept) state_d = StHold;
        StHold: begin
          if (trap) begin
            state_d = StTrap;
          end else if (dispatch && !accept) begin
            state_d = StEmpty;
          end
        end
        StTrap:  state_d = StTrap;
        default: state_d = StEmpty;
      endcase
    end
  end

  // Set on dispatch is applied after the writeback clear so that it wins.
  always_comb begin
    busy_d = busy_q;
    if (bus.wb_valid) begin
      busy_d[bus.wb_rd] = 1'b0;
    end
    if (dispatch && hold_q.wr_reg && (hold_q.rd != '0)) begin
      busy_d[hold_q.rd] = 1'b1;
    end
    if (bus.flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    stall_d = stall_q;
    if (stall && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StEmpty;
      hold_q  <= '0;
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  for (genvar i = 0; i < NUM_ENT; i++) begin : gen_credit
    dispatch_credit_ctr #(
      .CREDITS (CREDITS)
    ) u_ctr (
      .clk_i   (clk),
      .rst_ni  (reset),
      .flush_i (bus.flush),
      .take_i  (take[i]),
      .give_i  (bus.rs_free[i]),
      .zero_o  (cred_zero[i])
    );
  end

  assign bus.dec_ready    = dec_ready;
  assign bus.disp_valid   = take;
  assign bus.disp_rs1     = hold_q.rs1;
  assign bus.disp_rs2     = hold_q.rs2;
  assign bus.disp_rd      = hold_q.rd;
  assign bus.disp_wr_reg  = hold_q.wr_reg;
  assign bus.illegal_trap = trap;
  assign bus.stall_cnt    = stall_q;

endmodule
